// File: rtl/encoder32x5_seq.sv
// encoder32x5_seq: captures a request word and emits the index of each set bit over a valid/ready handshake.
// Define ENC_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
module encoder32x5_seq #(
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [2**AW-1:0]  y,
    input  logic              ready,
    output logic [AW-1:0]     a,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic              none,
    output logic [AW:0]       count
);
    localparam int N = 2**AW;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]   r_state;
    logic [N-1:0] r_pend;
    logic [AW-1:0] r_a;
    logic         r_done;
    logic         r_none;
    logic [AW:0]  r_count;
    logic [N-1:0] w_rem;
    logic [AW-1:0] w_first_y;
    logic [AW-1:0] w_first_rem;

    // Later matches overwrite earlier ones, so loop direction sets the priority.
    function automatic logic [AW-1:0] pick(input logic [N-1:0] m);
        logic [AW-1:0] p;
        p = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++)
            if (m[i]) p = i[AW-1:0];
`else
        for (int i = N - 1; i >= 0; i--)
            if (m[i]) p = i[AW-1:0];
`endif
        return p;
    endfunction

    always_comb begin
        w_rem       = r_pend & ~(N'(1) << r_a);
        w_first_y   = pick(y);
        w_first_rem = pick(w_rem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_a     <= '0;
            r_done  <= 1'b0;
            r_none  <= 1'b0;
            r_count <= '0;
        end else if (en) begin
            r_done <= 1'b0;
            r_none <= 1'b0;
            if (r_state == IDLE) begin
                if (load && |y) begin
                    r_pend  <= y;
                    r_a     <= w_first_y;
                    r_count <= '0;
                    r_state <= EMIT;
                end else if (load) begin
                    r_none  <= 1'b1;
                    r_count <= '0;
                end
            end else if (ready) begin
                r_pend  <= w_rem;
                r_a     <= w_first_rem;
                r_count <= r_count + 1'b1;
                if (w_rem == '0) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign a     = r_a;
    assign valid = r_state == EMIT;
    assign busy  = r_state == EMIT;
    assign done  = r_done;
    assign none  = r_none;
    assign count = r_count;
endmodule
